cram_port_arbiter: RTL and testbench

CRAM_PORT_ARBITER -- requirements
Module: cram_port_arbiter

---
 rtl/cram_port_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_cram_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cram_port_arbiter.sv
// Shares one single-port byte RAM between a CPU port (always wins) and the 16-bit BK and 8-bit SS ports (round-robin).
// Latency: CPU read data at t+1; BK ack 3 cycles after request, SS ack 2; each CPU preemption adds one cycle.
// Backpressure: the CPU is never stalled; a BK/SS op preempted by the CPU holds its state and retries next cycle.
module cram_port_arbiter (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [16:0] cpu_addr,
    input  logic [7:0]  cpu_di,
    output logic [7:0]  cpu_do,
    output logic        cpu_valid,
    input  logic        bk_req,
    input  logic        bk_we,
    input  logic [15:0] bk_addr,
    input  logic [15:0] bk_di,
    output logic [15:0] bk_q,
    output logic        bk_ack,
    input  logic        ss_req,
    input  logic        ss_we,
    input  logic [16:0] ss_addr,
    input  logic [7:0]  ss_di,
    output logic [7:0]  ss_q,
    output logic        ss_ack,
    output logic [16:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_d,
    input  logic [7:0]  ram_q
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] BK_LO   = 3'd1;
    localparam logic [2:0] BK_HI   = 3'd2;
    localparam logic [2:0] BK_DONE = 3'd3;
    localparam logic [2:0] SS_OP   = 3'd4;
    localparam logic [2:0] SS_DONE = 3'd5;

    // Owner of the byte that ram_q will present next cycle (reads only).
    localparam logic [2:0] OWN_NONE  = 3'd0;
    localparam logic [2:0] OWN_CPU   = 3'd1;
    localparam logic [2:0] OWN_BK_LO = 3'd2;
    localparam logic [2:0] OWN_BK_HI = 3'd3;
    localparam logic [2:0] OWN_SS    = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic        rr;
    logic        rr_nxt;
    logic        bk_armed;
    logic        ss_armed;
    logic [2:0]  owner;
    logic [2:0]  owner_nxt;
    logic [16:0] last_addr;
    logic [7:0]  last_d;
    logic [7:0]  cpu_do_r;
    logic [7:0]  bk_lo_r;
    logic [7:0]  bk_hi_r;
    logic [7:0]  ss_q_r;

    logic        cpu_issue;
    logic        fsm_op;
    logic        fsm_issue;
    logic [16:0] fsm_addr;
    logic        fsm_we;
    logic [7:0]  fsm_d;
    logic        bk_go;
    logic        ss_go;

    // Nothing reaches the RAM while reset is asserted, not even a CPU strobe.
    assign cpu_issue = cpu_req & reset_n;
    assign fsm_op    = (state == BK_LO) | (state == BK_HI) | (state == SS_OP);
    assign fsm_issue = fsm_op & ~cpu_issue & reset_n;

    assign bk_go = bk_req & bk_armed;
    assign ss_go = ss_req & ss_armed;

    assign bk_ack = (state == BK_DONE);
    assign ss_ack = (state == SS_DONE);

    // Read data is bypassed from ram_q in the cycle it arrives, then held in a register until the next read.
    assign cpu_do = (owner == OWN_CPU)   ? ram_q : cpu_do_r;
    assign bk_q   = {(owner == OWN_BK_HI) ? ram_q : bk_hi_r,
                     (owner == OWN_BK_LO) ? ram_q : bk_lo_r};
    assign ss_q   = (owner == OWN_SS)    ? ram_q : ss_q_r;

    // Byte operation the FSM wants to issue in its current state.
    always_comb begin
        fsm_addr = 17'd0;
        fsm_we   = 1'b0;
        fsm_d    = 8'd0;
        case (state)
            BK_LO: begin
                fsm_addr = {bk_addr, 1'b0};
                fsm_we   = bk_we;
                fsm_d    = bk_di[7:0];
            end
            BK_HI: begin
                fsm_addr = {bk_addr, 1'b1};
                fsm_we   = bk_we;
                fsm_d    = bk_di[15:8];
            end
            SS_OP: begin
                fsm_addr = ss_addr;
                fsm_we   = ss_we;
                fsm_d    = ss_di;
            end
            default: begin
                fsm_addr = 17'd0;
                fsm_we   = 1'b0;
                fsm_d    = 8'd0;
            end
        endcase
    end

    // RAM port mux: CPU first, then FSM, otherwise hold the last address/data with write disabled.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = last_addr;
        ram_d    = last_d;
        if (cpu_issue) begin
            ram_we   = cpu_wr;
            ram_addr = cpu_addr;
            ram_d    = cpu_di;
        end else if (fsm_issue) begin
            ram_we   = fsm_we;
            ram_addr = fsm_addr;
            ram_d    = fsm_d;
        end
    end

    // Tag the upcoming ram_q byte with whoever issued a read this cycle.
    always_comb begin
        owner_nxt = OWN_NONE;
        if (cpu_issue) begin
            owner_nxt = cpu_wr ? OWN_NONE : OWN_CPU;
        end else if (fsm_issue && !fsm_we) begin
            case (state)
                BK_LO:   owner_nxt = OWN_BK_LO;
                BK_HI:   owner_nxt = OWN_BK_HI;
                SS_OP:   owner_nxt = OWN_SS;
                default: owner_nxt = OWN_NONE;
            endcase
        end
    end

    // Next-state and round-robin logic; op states advance only when their byte was actually issued.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        case (state)
            IDLE: begin
                if (bk_go && (!ss_go || !rr)) begin
                    state_nxt = BK_LO;
                    rr_nxt    = 1'b1;
                end else if (ss_go) begin
                    state_nxt = SS_OP;
                    rr_nxt    = 1'b0;
                end
            end
            BK_LO:   state_nxt = fsm_issue ? BK_HI   : BK_LO;
            BK_HI:   state_nxt = fsm_issue ? BK_DONE : BK_HI;
            BK_DONE: state_nxt = IDLE;
            SS_OP:   state_nxt = fsm_issue ? SS_DONE : SS_OP;
            SS_DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, fairness bit and read-owner tag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rr    <= 1'b0;
            owner <= OWN_NONE;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
            owner <= owner_nxt;
        end
    end

    // A requester is disarmed by its ack and rearmed once its req is seen low.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bk_armed <= 1'b1;
            ss_armed <= 1'b1;
        end else begin
            if (bk_ack)       bk_armed <= 1'b0;
            else if (!bk_req) bk_armed <= 1'b1;
            if (ss_ack)       ss_armed <= 1'b0;
            else if (!ss_req) ss_armed <= 1'b1;
        end
    end

    // Remember the last issued address/data so the idle RAM port stays quiet.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            last_addr <= 17'd0;
            last_d    <= 8'd0;
        end else if (cpu_issue || fsm_issue) begin
            last_addr <= ram_addr;
            last_d    <= ram_d;
        end
    end

    // Read-data holding registers and the CPU valid strobe.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cpu_valid <= 1'b0;
            cpu_do_r  <= 8'd0;
            bk_lo_r   <= 8'd0;
            bk_hi_r   <= 8'd0;
            ss_q_r    <= 8'd0;
        end else begin
            cpu_valid <= cpu_issue & ~cpu_wr;
            cpu_do_r  <= cpu_do;
            bk_lo_r   <= bk_q[7:0];
            bk_hi_r   <= bk_q[15:8];
            ss_q_r    <= ss_q;
        end
    end

endmodule

// File: tb/tb_cram_port_arbiter.sv
// Bench for cram_port_arbiter: byte RAM model, vector table of port transactions, scoreboard of expected read data.
// Latency: acks checked against fixed cycle counts, CPU data one cycle after its strobe.
// Backpressure: CPU writes are injected into in-flight BK/SS ops to exercise preemption and retry.
module tb_cram_port_arbiter;

    localparam logic [1:0] K_BK  = 2'd0;
    localparam logic [1:0] K_SS  = 2'd1;
    localparam logic [1:0] K_CPU = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic        we;
        logic [16:0] addr;
        logic [15:0] di;
        logic [15:0] exp;      // read data, or the value the q output must still hold after a write
        int          lat;      // cycle index of the ack, counted from the request cycle
        int          inj;      // cycle index at which a CPU write is injected, -1 for none
        logic [16:0] inj_addr;
        logic [7:0]  inj_di;
    } vec_t;

    logic        clk_sys;
    logic        reset_n;
    logic        cpu_req, cpu_wr;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_di, cpu_do;
    logic        cpu_valid;
    logic        bk_req, bk_we;
    logic [15:0] bk_addr, bk_di, bk_q;
    logic        bk_ack;
    logic        ss_req, ss_we;
    logic [16:0] ss_addr;
    logic [7:0]  ss_di, ss_q;
    logic        ss_ack;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q;

    logic [7:0]  mem [0:131071];

    logic [15:0] bk_sb [$];
    logic [7:0]  ss_sb [$];
    logic [7:0]  cpu_sb [$];

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs [19];

    cram_port_arbiter dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .cpu_req  (cpu_req),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_di   (cpu_di),
        .cpu_do   (cpu_do),
        .cpu_valid(cpu_valid),
        .bk_req   (bk_req),
        .bk_we    (bk_we),
        .bk_addr  (bk_addr),
        .bk_di    (bk_di),
        .bk_q     (bk_q),
        .bk_ack   (bk_ack),
        .ss_req   (ss_req),
        .ss_we    (ss_we),
        .ss_addr  (ss_addr),
        .ss_di    (ss_di),
        .ss_q     (ss_q),
        .ss_ack   (ss_ack),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_d    (ram_d),
        .ram_q    (ram_q)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Synchronous single-port byte RAM, read data one cycle after the address.
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack / cpu_valid pops one expectation and compares the returned data.
    always @(negedge clk_sys) begin
        if (bk_ack) begin
            if (bk_sb.size() == 0) chk("bk_ack_unexpected", 32'(bk_ack), 32'd0);
            else chk("bk_q", 32'(bk_q), 32'(bk_sb.pop_front()));
        end
        if (ss_ack) begin
            if (ss_sb.size() == 0) chk("ss_ack_unexpected", 32'(ss_ack), 32'd0);
            else chk("ss_q", 32'(ss_q), 32'(ss_sb.pop_front()));
        end
        if (cpu_valid) begin
            if (cpu_sb.size() == 0) chk("cpu_valid_unexpected", 32'(cpu_valid), 32'd0);
            else chk("cpu_do", 32'(cpu_do), 32'(cpu_sb.pop_front()));
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int got;
        got = -1;
        @(posedge clk_sys); #1;
        if (v.kind == K_CPU) begin
            cpu_req  = 1'b1;
            cpu_wr   = v.we;
            cpu_addr = v.addr;
            cpu_di   = v.di[7:0];
            if (!v.we) cpu_sb.push_back(v.exp[7:0]);
            @(negedge clk_sys);
            chk($sformatf("v%0d_cpu_ram_port", idx), 32'({ram_we, ram_addr}), 32'({v.we, v.addr}));
            @(posedge clk_sys); #1;
            cpu_req = 1'b0;
            @(negedge clk_sys);
            chk($sformatf("v%0d_cpu_valid", idx), 32'(cpu_valid), 32'(!v.we));
            if (v.we) chk($sformatf("v%0d_cpu_do_hold", idx), 32'(cpu_do), 32'(v.exp[7:0]));
        end else begin
            if (v.kind == K_BK) begin
                bk_req  = 1'b1;
                bk_we   = v.we;
                bk_addr = v.addr[15:0];
                bk_di   = v.di;
                bk_sb.push_back(v.exp);
            end else begin
                ss_req  = 1'b1;
                ss_we   = v.we;
                ss_addr = v.addr;
                ss_di   = v.di[7:0];
                ss_sb.push_back(v.exp[7:0]);
            end
            for (int c = 0; c < 16; c++) begin
                if (c == v.inj) begin
                    cpu_req  = 1'b1;
                    cpu_wr   = 1'b1;
                    cpu_addr = v.inj_addr;
                    cpu_di   = v.inj_di;
                end else begin
                    cpu_req = 1'b0;
                end
                @(negedge clk_sys);
                if (c == v.inj)
                    chk($sformatf("v%0d_inj_ram_port", idx), 32'({ram_we, ram_addr, ram_d}),
                        32'({1'b1, v.inj_addr, v.inj_di}));
                if (bk_ack || ss_ack) begin
                    got = c;
                    break;
                end
                @(posedge clk_sys); #1;
            end
            @(posedge clk_sys); #1;
            cpu_req = 1'b0;
            bk_req  = 1'b0;
            ss_req  = 1'b0;
            chk($sformatf("v%0d_ack_latency", idx), 32'(got), 32'(v.lat));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        int   acks;
        int   got;
        logic [3:0] order;
        logic drop_bk, drop_ss;
        vec_t v;

        //              kind   we    addr       di        exp       lat inj inj_addr   inj_di
        vecs[0]  = '{K_BK,  1'b1, 17'h00010, 16'hA55A, 16'h0000, 3, -1, 17'h00000, 8'h00};
        vecs[1]  = '{K_CPU, 1'b0, 17'h00020, 16'h0000, 16'h005A, 0, -1, 17'h00000, 8'h00};
        vecs[2]  = '{K_CPU, 1'b0, 17'h00021, 16'h0000, 16'h00A5, 0, -1, 17'h00000, 8'h00};
        vecs[3]  = '{K_BK,  1'b0, 17'h00010, 16'h0000, 16'hA55A, 3, -1, 17'h00000, 8'h00};
        vecs[4]  = '{K_BK,  1'b0, 17'h00010, 16'h0000, 16'h775A, 4,  2, 17'h00021, 8'h77};
        vecs[5]  = '{K_SS,  1'b1, 17'h1FFFF, 16'h00C3, 16'h0000, 2, -1, 17'h00000, 8'h00};
        vecs[6]  = '{K_CPU, 1'b0, 17'h1FFFF, 16'h0000, 16'h00C3, 0, -1, 17'h00000, 8'h00};
        vecs[7]  = '{K_BK,  1'b1, 17'h0FFFF, 16'h1234, 16'h775A, 3, -1, 17'h00000, 8'h00};
        vecs[8]  = '{K_SS,  1'b0, 17'h1FFFE, 16'h0000, 16'h0034, 2, -1, 17'h00000, 8'h00};
        vecs[9]  = '{K_SS,  1'b0, 17'h1FFFF, 16'h0000, 16'h0012, 2, -1, 17'h00000, 8'h00};
        vecs[10] = '{K_CPU, 1'b1, 17'h00100, 16'h009E, 16'h00C3, 0, -1, 17'h00000, 8'h00};
        vecs[11] = '{K_SS,  1'b0, 17'h00100, 16'h0000, 16'h009E, 3,  1, 17'h00101, 8'h44};
        vecs[12] = '{K_BK,  1'b0, 17'h00080, 16'h0000, 16'h449E, 3, -1, 17'h00000, 8'h00};
        vecs[13] = '{K_SS,  1'b1, 17'h00100, 16'h005B, 16'h009E, 3,  1, 17'h00200, 8'h11};
        vecs[14] = '{K_CPU, 1'b0, 17'h00100, 16'h0000, 16'h005B, 0, -1, 17'h00000, 8'h00};
        vecs[15] = '{K_CPU, 1'b0, 17'h00200, 16'h0000, 16'h0011, 0, -1, 17'h00000, 8'h00};
        vecs[16] = '{K_BK,  1'b1, 17'h00080, 16'hBEEF, 16'h449E, 4,  1, 17'h00300, 8'h66};
        vecs[17] = '{K_BK,  1'b0, 17'h00080, 16'h0000, 16'hBEEF, 3, -1, 17'h00000, 8'h00};
        vecs[18] = '{K_CPU, 1'b0, 17'h00300, 16'h0000, 16'h0066, 0, -1, 17'h00000, 8'h00};

        // Reset state, with a CPU write strobe present that must not reach the RAM.
        reset_n  = 1'b0;
        cpu_req  = 1'b1; cpu_wr = 1'b1; cpu_addr = 17'h1234; cpu_di = 8'hFF;
        bk_req   = 1'b0; bk_we = 1'b0; bk_addr = 16'h0; bk_di = 16'h0;
        ss_req   = 1'b0; ss_we = 1'b0; ss_addr = 17'h0; ss_di = 8'h0;
        #2;
        chk("reset_strobes", 32'({ram_we, bk_ack, ss_ack, cpu_valid}), 32'd0);
        chk("reset_ram_port", 32'({ram_addr, ram_d}), 32'd0);
        chk("reset_q_outputs", 32'({cpu_do, bk_q}), 32'd0);
        chk("reset_ss_q", 32'(ss_q), 32'd0);
        @(negedge clk_sys);
        chk("reset_ram_we_after_edge", 32'(ram_we), 32'd0);
        cpu_req = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

        // Idle port: write disabled, address/data held at the last issued op.
        repeat (2) @(negedge clk_sys);
        chk("idle_ram_port", 32'({ram_we, ram_addr}), 32'({1'b0, 17'h00300}));

        // Reset during BK_HI of a write to 0x1FFFE/0x1FFFF.
        @(posedge clk_sys); #1;
        bk_req = 1'b1; bk_we = 1'b1; bk_addr = 16'hFFFF; bk_di = 16'hABCD;
        @(posedge clk_sys);
        @(posedge clk_sys); #1;
        chk("bk_hi_before_reset", 32'({ram_we, ram_addr, ram_d}), 32'({1'b1, 17'h1FFFF, 8'hAB}));
        #1 reset_n = 1'b0;
        acks = 0;
        @(negedge clk_sys);
        chk("mid_reset_ram_port", 32'({ram_we, ram_addr}), 32'd0);
        if (bk_ack) acks++;
        @(posedge clk_sys); #1;
        bk_req = 1'b0; bk_we = 1'b0;
        @(negedge clk_sys);
        if (bk_ack || ram_we) acks++;
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk_sys);
            if (bk_ack) acks++;
        end
        chk("reset_abort_no_ack", 32'(acks), 32'd0);
        chk("post_reset_bk_q", 32'(bk_q), 32'd0);
        v = '{K_CPU, 1'b0, 17'h1FFFF, 16'h0000, 16'h0012, 0, -1, 17'h00000, 8'h00};
        run_vec(v, 100);
        v = '{K_SS,  1'b0, 17'h1FFFE, 16'h0000, 16'h00CD, 2, -1, 17'h00000, 8'h00};
        run_vec(v, 101);

        // Fairness: both held, each dropped for one cycle after its ack.
        bk_we = 1'b0; ss_we = 1'b0; bk_addr = 16'h0010; ss_addr = 17'h00200;
        repeat (2) begin
            bk_sb.push_back(16'h775A);
            ss_sb.push_back(8'h11);
        end
        @(posedge clk_sys); #1;
        bk_req = 1'b1; ss_req = 1'b1;
        n = 0; order = 4'b0000;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_sys);
            drop_bk = bk_ack;
            drop_ss = ss_ack;
            if (bk_ack && n < 4) begin order[n] = 1'b0; n++; end
            if (ss_ack && n < 4) begin order[n] = 1'b1; n++; end
            if (n == 4) break;
            @(posedge clk_sys); #1;
            bk_req = !drop_bk;
            ss_req = !drop_ss;
        end
        chk("fair_grant_count", 32'(n), 32'd4);
        chk("fair_order", 32'(order), 32'(4'b1010));

        // SS held high after its ack must stay disarmed; one low cycle rearms it.
        @(posedge clk_sys); #1;
        bk_req = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk_sys);
            if (ss_ack || bk_ack) acks++;
        end
        chk("disarm_no_regrant", 32'(acks), 32'd0);
        @(posedge clk_sys); #1;
        ss_req = 1'b0;
        ss_sb.push_back(8'h11);
        @(posedge clk_sys); #1;
        ss_req = 1'b1;
        got = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_sys);
            if (ss_ack) begin
                got = c;
                break;
            end
        end
        @(posedge clk_sys); #1;
        ss_req = 1'b0;
        chk("rearm_ack_latency", 32'(got), 32'd2);

        repeat (3) @(posedge clk_sys);
        chk("bk_sb_empty", 32'(bk_sb.size()), 32'd0);
        chk("ss_sb_empty", 32'(ss_sb.size()), 32'd0);
        chk("cpu_sb_empty", 32'(cpu_sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
